// File: rtl/move_command_sequencer.sv
// move_command_sequencer: queues rover move commands ({angle[11:7], distance[6:0]}) in a
// small FIFO and issues them one at a time to the motor signal stream. It waits for move_done,
// inserts a settle gap after each move, faults on a per-move timeout and supports abort.
// Ports: clock, reset (async, active low); cmd_valid/cmd_data/cmd_accept (push side);
//   abort, clear_fault, move_done (control in); command_ready/command/motor_abort (to motor
//   stream); busy, queue_count, fault, moves_completed, state (status/debug).
module move_command_sequencer #(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int SETTLE_CYCLES  = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [11:0]       cmd_data,
  output logic              cmd_accept,
  input  logic              abort,
  input  logic              clear_fault,
  input  logic              move_done,
  output logic              command_ready,
  output logic [11:0]       command,
  output logic              motor_abort,
  output logic              busy,
  output logic [ADDR_W:0]   queue_count,
  output logic              fault,
  output logic [7:0]        moves_completed,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [ADDR_W:0] FULL_COUNT  = DEPTH[ADDR_W:0];
  localparam logic [31:0]     TIMER_LAST  = TIMEOUT_CYCLES - 1;
  // A zero settle length still spends one cycle in SETTLE.
  localparam logic [31:0]     SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 0 : SETTLE_CYCLES - 1;

  // FIFO storage and pointers
  logic [11:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [11:0]       head;

  // Counters
  logic [31:0] timer;
  logic [31:0] settle_cnt;

  // Decoded events
  logic abort_hit;
  logic timeout_hit;
  logic flush;
  logic push;
  logic pop;
  logic head_ok;
  logic load_cmd;

  // Next-state / next-output values
  logic [2:0]  state_nxt;
  logic        command_ready_nxt;
  logic        motor_abort_nxt;
  logic        fault_nxt;
  logic        busy_nxt;
  logic [7:0]  moves_nxt;
  logic [31:0] timer_nxt;
  logic [31:0] settle_nxt;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign cmd_accept = (queue_count != FULL_COUNT) && (state != S_FAULT);

  assign head    = mem[rd_ptr];
  // angle==0 or distance==0 would underflow the motor stream; this also covers 12'h000.
  assign head_ok = (head[11:7] != 5'd0) && (head[6:0] != 7'd0);

  assign abort_hit   = abort && (state != S_FAULT);
  // move_done and abort both outrank the timeout.
  assign timeout_hit = (state == S_WAIT) && !move_done && !abort_hit && (timer == TIMER_LAST);
  assign flush       = abort_hit || timeout_hit;
  // A push coinciding with a flush is dropped.
  assign push        = cmd_valid && cmd_accept && !flush;
  assign pop         = (state == S_IDLE) && (queue_count != '0) && !abort_hit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Invalid heads are popped and dropped without leaving IDLE.
        if (pop && head_ok) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = abort_hit ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort_hit)        state_nxt = S_IDLE;
        else if (move_done)   state_nxt = S_SETTLE;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_SETTLE: begin
        if (abort_hit || (settle_cnt == SETTLE_LAST)) state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (clear_fault) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (next values of the registered outputs and counters)
  // ---------------------------------------------------------------------------
  always_comb begin
    load_cmd   = 1'b0;
    fault_nxt  = fault;
    moves_nxt  = moves_completed;
    timer_nxt  = timer;
    settle_nxt = settle_cnt;
    case (state)
      S_IDLE: begin
        load_cmd = pop && head_ok;
      end
      S_ISSUE: begin
        timer_nxt = '0;
      end
      S_WAIT: begin
        timer_nxt = timer + 32'd1;
        if (move_done && !abort_hit) begin
          moves_nxt  = moves_completed + 8'd1;
          settle_nxt = '0;
        end
      end
      S_SETTLE: begin
        settle_nxt = settle_cnt + 32'd1;
      end
      S_FAULT: begin
        if (clear_fault) fault_nxt = 1'b0;
      end
      default: begin
        load_cmd = 1'b0;
      end
    endcase
    if (timeout_hit) fault_nxt = 1'b1;
    // The strobe is registered so it is high exactly during the ISSUE cycle.
    command_ready_nxt = (state_nxt == S_ISSUE);
    // Aborting from IDLE or SETTLE has no motor activity to stop.
    motor_abort_nxt   = timeout_hit ||
                        (abort_hit && ((state == S_ISSUE) || (state == S_WAIT)));
    busy_nxt          = (state_nxt != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      command         <= '0;
      command_ready   <= 1'b0;
      motor_abort     <= 1'b0;
      fault           <= 1'b0;
      busy            <= 1'b0;
      moves_completed <= '0;
      timer           <= '0;
      settle_cnt      <= '0;
    end else begin
      if (load_cmd) command <= head;
      command_ready   <= command_ready_nxt;
      motor_abort     <= motor_abort_nxt;
      fault           <= fault_nxt;
      busy            <= busy_nxt;
      moves_completed <= moves_nxt;
      timer           <= timer_nxt;
      settle_cnt      <= settle_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH (power of two).
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

endmodule

// File: tb/tb_move_command_sequencer.sv
module tb_move_command_sequencer;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [11:0]       cmd_data = '0;
  logic              cmd_accept;
  logic              abort = 1'b0;
  logic              clear_fault = 1'b0;
  logic              move_done = 1'b0;
  logic              command_ready;
  logic [11:0]       command;
  logic              motor_abort;
  logic              busy;
  logic [ADDR_W:0]   queue_count;
  logic              fault;
  logic [7:0]        moves_completed;
  logic [2:0]        state;

  move_command_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_accept(cmd_accept), .abort(abort), .clear_fault(clear_fault),
    .move_done(move_done), .command_ready(command_ready), .command(command),
    .motor_abort(motor_abort), .busy(busy), .queue_count(queue_count),
    .fault(fault), .moves_completed(moves_completed), .state(state)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int exp_moves = 0;
  int strobe_cyc[$];
  logic [11:0] strobe_cmd[$];

  // Records every issue strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset === 1'b1 && command_ready === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_cmd.push_back(command);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_one(input logic [11:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe_n(input int target, input string tag);
    int n = 0;
    while (strobe_cyc.size() < target && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(strobe_cyc.size() >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(state == 3'd0 && queue_count == '0) && n < 300) begin
      tick();
      n++;
    end
    check(tag, {29'd0, state}, 0);
  endtask

  task automatic done_after(input int d);
    repeat (d) tick();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
  endtask

  function automatic logic cmd_is_valid(input logic [11:0] c);
    return (c[11:7] != 0) && (c[6:0] != 0);
  endfunction

  initial begin
    int base;
    int s;
    int t0;
    logic [11:0] d;
    logic [11:0] mq[$];
    logic [11:0] burst[3];

    // ---------------- reset state ----------------
    #2 reset = 1'b0;
    tick(); tick();
    check("rst_state", {29'd0, state}, 0);
    check("rst_count", {28'd0, queue_count}, 0);
    check("rst_ready", {31'd0, command_ready}, 0);
    check("rst_command", {20'd0, command}, 0);
    check("rst_fault", {31'd0, fault}, 0);
    check("rst_moves", {24'd0, moves_completed}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_accept", {31'd0, cmd_accept}, 1);
    reset = 1'b1;
    tick();

    // ---------------- single push latency ----------------
    push_one(12'h283);
    check("t1_ready_c1", {31'd0, command_ready}, 0);
    check("t1_count_c1", {28'd0, queue_count}, 1);
    tick();
    check("t1_ready_c2", {31'd0, command_ready}, 1);
    check("t1_command", {20'd0, command}, 12'h283);
    check("t1_busy", {31'd0, busy}, 1);
    tick();
    check("t1_ready_c3", {31'd0, command_ready}, 0);
    check("t1_state_wait", {29'd0, state}, 2);
    done_after(5);
    exp_moves++;
    wait_idle("t1_idle");
    check("t1_moves", {24'd0, moves_completed}, 32'(exp_moves));

    // ---------------- three back-to-back moves ----------------
    burst[0] = 12'h103; burst[1] = 12'h3c5; burst[2] = 12'h0ff;
    base = strobe_cyc.size();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = burst[i];
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe_n(base + k + 1, $sformatf("t2_strobe%0d", k));
      if (strobe_cyc.size() > base + k) begin
        s = strobe_cyc[base + k];
        check($sformatf("t2_cmd%0d", k), {20'd0, strobe_cmd[base + k]}, {20'd0, burst[k]});
        while (cyc < s + 10) tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        exp_moves++;
      end
    end
    if (strobe_cyc.size() >= base + 3) begin
      check("t2_first_latency", 32'(strobe_cyc[base] - t0), 2);
      check("t2_gap01", 32'(strobe_cyc[base + 1] - strobe_cyc[base]), 16);
      check("t2_gap12", 32'(strobe_cyc[base + 2] - strobe_cyc[base + 1]), 16);
    end
    wait_idle("t2_idle");
    check("t2_moves", {24'd0, moves_completed}, 32'(exp_moves));
    check("t2_count", {28'd0, queue_count}, 0);

    // ---------------- overfill while busy, then timeout ----------------
    base = strobe_cyc.size();
    push_one(12'h081);
    wait_strobe_n(base + 1, "t3_first");
    mq.delete();
    for (int i = 0; i < 9; i++) begin
      d = {i[4:0] + 5'd1, i[6:0] + 7'd10};
      cmd_valid = 1'b1;
      cmd_data  = d;
      check($sformatf("t3_accept%0d", i), {31'd0, cmd_accept}, 32'(mq.size() < DEPTH));
      if (mq.size() < DEPTH) mq.push_back(d);
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_full_count", {28'd0, queue_count}, 32'(mq.size()));
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    exp_moves++;
    for (int k = 0; k < 4; k++) begin
      wait_strobe_n(base + 2 + k, $sformatf("t3_strobe%0d", k));
      check($sformatf("t3_order%0d", k), {20'd0, command}, {20'd0, mq[k]});
      if (k == 0) check("t3_count_after_pop", {28'd0, queue_count}, 32'(DEPTH - 1));
      if (k < 3) begin
        done_after(3);
        exp_moves++;
      end
    end
    s = (strobe_cyc.size() > 0) ? strobe_cyc[strobe_cyc.size() - 1] : cyc;
    while (cyc < s + TIMEOUT) tick();
    check("t4_fault_early", {31'd0, fault}, 0);
    check("t4_state_wait", {29'd0, state}, 2);
    tick();
    check("t4_fault", {31'd0, fault}, 1);
    check("t4_motor_abort", {31'd0, motor_abort}, 1);
    check("t4_state_fault", {29'd0, state}, 4);
    check("t4_flushed", {28'd0, queue_count}, 0);
    check("t4_accept", {31'd0, cmd_accept}, 0);
    check("t4_moves", {24'd0, moves_completed}, 32'(exp_moves));
    tick();
    check("t4_motor_abort_end", {31'd0, motor_abort}, 0);
    push_one(12'h0a1);
    check("t4_push_ignored", {28'd0, queue_count}, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_ignored", {29'd0, state}, 4);
    check("t4_abort_no_pulse", {31'd0, motor_abort}, 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("t4_cleared_state", {29'd0, state}, 0);
    check("t4_cleared_fault", {31'd0, fault}, 0);

    // ---------------- abort in WAIT_DONE ----------------
    base = strobe_cyc.size();
    push_one(12'h0a2);
    wait_strobe_n(base + 1, "t5_strobe");
    for (int i = 0; i < 4; i++) push_one({5'd3, 7'(i + 1)});
    check("t5_queued", {28'd0, queue_count}, 4);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 12'h3ff;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("t5_motor_abort", {31'd0, motor_abort}, 1);
    check("t5_flushed", {28'd0, queue_count}, 0);
    check("t5_state", {29'd0, state}, 0);
    tick();
    check("t5_motor_abort_end", {31'd0, motor_abort}, 0);
    repeat (30) tick();
    check("t5_no_strobe", 32'(strobe_cyc.size()), 32'(base + 1));
    check("t5_moves", {24'd0, moves_completed}, 32'(exp_moves));

    // ---------------- invalid commands discarded, reset mid-move ----------------
    base = strobe_cyc.size();
    push_one(12'h000);
    push_one(12'h005);
    push_one(12'h081);
    wait_strobe_n(base + 1, "t6_strobe");
    check("t6_command", {20'd0, command}, 12'h081);
    repeat (3) tick();
    check("t6_only_one", 32'(strobe_cyc.size()), 32'(base + 1));
    check("t6_in_wait", {29'd0, state}, 2);
    reset = 1'b0;
    #2;
    check("t6_rst_state", {29'd0, state}, 0);
    check("t6_rst_command", {20'd0, command}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_moves", {24'd0, moves_completed}, 0);
    check("t6_rst_accept", {31'd0, cmd_accept}, 1);
    tick();
    reset = 1'b1;
    tick();
    exp_moves = 0;

    // ---------------- randomized bursts against the queue model ----------------
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [11:0] expq[$];
      base = strobe_cyc.size();
      n = $urandom_range(1, 6);
      expq.delete();
      for (int i = 0; i < n; i++) begin
        logic [4:0] a;
        logic [6:0] ds;
        a  = 5'($urandom_range(0, 31));
        ds = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) a = '0;
        if ($urandom_range(0, 3) == 0) ds = '0;
        d = {a, ds};
        if (cmd_is_valid(d)) expq.push_back(d);
        push_one(d);
      end
      for (int k = 0; k < expq.size(); k++) begin
        wait_strobe_n(base + k + 1, $sformatf("r%0d_strobe%0d", r, k));
        if (strobe_cyc.size() > base + k)
          check($sformatf("r%0d_cmd%0d", r, k), {20'd0, strobe_cmd[base + k]}, {20'd0, expq[k]});
        done_after($urandom_range(1, 12));
        exp_moves++;
      end
      wait_idle($sformatf("r%0d_idle", r));
      repeat (6) tick();
      check($sformatf("r%0d_strobes", r), 32'(strobe_cyc.size()), 32'(base + expq.size()));
      check($sformatf("r%0d_moves", r), {24'd0, moves_completed}, 32'(exp_moves % 256));
      check($sformatf("r%0d_count", r), {28'd0, queue_count}, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
